// File: rtl/crypt_result_serializer.sv
// crypt_result_serializer: counts the round-enable window,
// captures the final word and streams it out MSB lane first.
module crypt_result_serializer #(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GLOBAL_EN,
  input  logic       EN_IN,
  input  logic [7:0] IN_1,
  input  logic [7:0] IN_2,
  input  logic [7:0] IN_3,
  input  logic [7:0] IN_4,
  input  logic       DREADY,
  output logic [7:0] DOUT,
  output logic       DVALID,
  output logic       DONE,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_END =
    CNT_W'(ROUNDS);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] rnd_cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       byte_idx;
  logic [1:0]       idx_n;
  logic [31:0]      word;
  logic [31:0]      word_n;
  logic [7:0]       dout_n;
  logic             dvalid_n;
  logic             done_n;
  logic             err_n;
  logic             en_d;
  logic             rise;

  function automatic logic [7:0] lane_sel(
    input logic [31:0] w,
    input logic [1:0]  idx
  );
    logic [7:0] r;
    unique case (idx)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

  assign rise = EN_IN & ~en_d;
  assign BUSY = (state != S_IDLE);

  // Next-state and next-output decode.
  always_comb begin
    state_n  = state;
    cnt_n    = rnd_cnt;
    idx_n    = byte_idx;
    word_n   = word;
    dout_n   = DOUT;
    dvalid_n = DVALID;
    done_n   = 1'b0;
    err_n    = ERR;
    unique case (state)
      S_IDLE: begin
        if (rise && GLOBAL_EN) begin
          state_n = S_RUN;
          cnt_n   = CNT_W'(1);
          err_n   = 1'b0;
        end
      end
      S_RUN: begin
        if (!GLOBAL_EN) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (EN_IN) begin
          if (rnd_cnt != CNT_MAX)
            cnt_n = rnd_cnt + CNT_W'(1);
        end else begin
          word_n = {IN_1, IN_2, IN_3, IN_4};
          if (rnd_cnt == CNT_END) begin
            state_n  = S_SHIFT;
            idx_n    = 2'd0;
            dvalid_n = 1'b1;
            dout_n   = IN_1;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_SHIFT: begin
        if (rise)
          err_n = 1'b1;
        if (DVALID && DREADY) begin
          if (byte_idx == 2'd3) begin
            dvalid_n = 1'b0;
            done_n   = 1'b1;
            state_n  = S_DONE;
          end else begin
            idx_n  = byte_idx + 2'd1;
            dout_n = lane_sel(word,
                              byte_idx + 2'd1);
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      rnd_cnt  <= '0;
      byte_idx <= 2'd0;
      word     <= 32'h0;
      en_d     <= 1'b0;
      DOUT     <= 8'h00;
      DVALID   <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_n;
      rnd_cnt  <= cnt_n;
      byte_idx <= idx_n;
      word     <= word_n;
      en_d     <= EN_IN;
      DOUT     <= dout_n;
      DVALID   <= dvalid_n;
      DONE     <= done_n;
      ERR      <= err_n;
    end
  end

endmodule

// File: doc/crypt_result_serializer.md
Name: crypt_result_serializer

Overview:
Downstream stage of the round counter. It watches the counter's round-enable window and counts the rounds. When the window closes it captures the final 32-bit round word from the four byte lanes. It then streams the word out one byte per transfer, MSB lane first, over a valid/ready handshake, and flags malformed or aborted runs.

Parameters:
ROUNDS, 32, number of cycles EN_IN must stay high for a valid run
CNT_W, 6, width of the round counter; must satisfy 2^CNT_W > ROUNDS

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  asynchronous active-high reset
GLOBAL_EN  input  1  global enable; the same signal that drives the counter stage
EN_IN  input  1  round-enable from the counter stage
IN_1  input  8  lane 1 round data (bits 31:24 of the word)
IN_2  input  8  lane 2 round data (bits 23:16)
IN_3  input  8  lane 3 round data (bits 15:8)
IN_4  input  8  lane 4 round data (bits 7:0)
DREADY  input  1  consumer ready
DOUT  output  8  serialized byte
DVALID  output  1  DOUT holds a valid byte
DONE  output  1  one-cycle pulse after the 4th byte transfers
BUSY  output  1  high whenever state != IDLE
ERR  output  1  sticky error flag; cleared on next run start or reset

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; DOUT=8'h00; DVALID=0; DONE=0; ERR=0.
  - rnd_cnt=0; byte_idx=0; word=32'h0; en_d=0.
  - BUSY=0 as a consequence of state=IDLE.
- en_d is EN_IN registered every cycle. A rising edge is EN_IN=1 && en_d=0.
- All outputs are registered, except BUSY, which is decoded from state.
- State IDLE:
  - Trigger: EN_IN rising edge with GLOBAL_EN=1.
  - Action: go to RUN, rnd_cnt=1, ERR=0.
  - All else ignored.
- State RUN:
  - EN_IN=1: rnd_cnt increments and saturates at 2^CNT_W-1.
  - EN_IN=0 (window closed), same edge:
    - word <= {IN_1,IN_2,IN_3,IN_4}.
    - If rnd_cnt==ROUNDS: go to SHIFT, byte_idx=0.
    - Otherwise: ERR=1, go to IDLE, no output.
  - GLOBAL_EN=0 in any RUN cycle takes priority: ERR=1, go to IDLE, no capture.
- State SHIFT:
  - DVALID=1 starting the cycle after capture; DOUT=word[31-8*byte_idx -: 8].
  - Transfer occurs on a cycle with DVALID && DREADY.
  - Per transfer: byte_idx++, and DOUT is updated to the next byte on the same edge.
  - With DVALID=1 and DREADY=0, DOUT and DVALID hold stable.
  - Transfer of byte_idx==3: DVALID=0, go to DONE.
  - GLOBAL_EN is ignored in SHIFT; a captured word is always fully delivered.
  - EN_IN rising edge during SHIFT is an overrun: ERR=1; the serialization completes unaffected and the new run is dropped.
- State DONE: DONE=1 for exactly one cycle, then go to IDLE. A rising edge on EN_IN in this cycle is dropped.
- Latency: capture edge is E. First byte valid at E+1. With DREADY held at 1, bytes are on E+1..E+4 and DONE is high at E+5.
- Reset mid-operation: immediate return to reset values. Any partially sent word is discarded.

Test Plan:
- Nominal run, DREADY=1:
  - Stimulus: GLOBAL_EN=1; EN_IN high 32 cycles; lanes 8'hDE,8'hAD,8'hBE,8'hEF at the fall.
  - Response: DOUT DE,AD,BE,EF on 4 consecutive DVALID cycles; DONE pulses once; ERR=0; BUSY low after DONE.
- Backpressure:
  - Stimulus: same run, DREADY=0 for 3 cycles after the first DVALID, then alternating 1/0.
  - Response: DOUT holds 8'hDE until accepted; exactly 4 transfers, in order; DONE once.
- Short window:
  - Stimulus: EN_IN high 31 cycles.
  - Response: ERR=1, DVALID never asserts, state back to IDLE; a following 32-cycle run clears ERR and outputs the correct word.
- Abort:
  - Stimulus: GLOBAL_EN dropped at round 10.
  - Response: ERR=1, no capture, BUSY=0 next cycle.
  - Stimulus: GLOBAL_EN dropped during SHIFT.
  - Response: all 4 bytes still delivered.
- Overrun and reset:
  - Stimulus: new EN_IN rising edge during SHIFT with DREADY=0.
  - Response: ERR=1, the original 4 bytes complete, the new run is ignored.
  - Stimulus: RST pulse mid-SHIFT (asynchronous, between clock edges).
  - Response: DVALID=0, DOUT=00, BUSY=0 immediately.
